status_text_render: RTL and testbench

- Parametrised successor to the fixed-layout status-string painter. Renders a LINE_CNT x LINE_LEN character grid at a programmable screen origin.
- Character content is held in a writable character buffer. Up to NUM_CNT right-aligned decimal fields are overlaid on it from frame-synchronous BCD snapshots.
- Supports per-line blinking and integer glyph scaling (1x/2x/4x).
- Sits in the pixel pipeline beside the big-string painters. Drives an external font ROM and returns a pixel-aligned draw flag to the colour mux.

---
 rtl/status_text_render.sv | 235 +++++++++++++++++++++++
 tb/tb_status_text_render.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/status_text_render.sv
// ----------------------------------------------------------------------------
// status_text_render
//
// Renders a LINE_CNT x LINE_LEN grid of 7-bit characters at (START_X, START_Y)
// in the pixel stream. Characters come from a writable buffer. Up to NUM_CNT
// right-aligned decimal fields are overlaid on it from a BCD snapshot that is
// taken once per frame. Lines can blink individually, and glyphs can be
// magnified by 2^SCALE_LOG2. An external font ROM is addressed with
// {char, glyph row}, and the returned row is turned into a pixel-aligned draw
// flag.
//
// Optional feature macro: STATUS_TEXT_ZERO_BLANK_EN
//   defined   : leading zeros of each field render as ' ' (digit 0 always shown)
//   undefined : every digit renders, including leading '0'
//
// Ports
//   clk_i          pixel clock
//   rst_n_i        asynchronous active-low reset
//   pix_x_i/_y_i   current pixel coordinate
//   frame_start_i  one-cycle pulse, captures num_bcd_i into the snapshot
//   wr_en_i        character buffer write strobe
//   wr_line_i      write line index
//   wr_pos_i       write column index
//   wr_char_i      ASCII code to write
//   num_bcd_i      BCD digits, field k digit d at [(k*NUM_DIGITS+d)*4 +: 4]
//   blink_mask_i   bit n set: line n blinks
//   rom_addr_o     font ROM address {char, glyph row}
//   rom_data_i     font ROM row, MSB = leftmost pixel
//   draw_o         lit text pixel, latency ROM_LATENCY+2
//   in_region_o    pixel inside the grid rectangle, same latency as draw_o
// ----------------------------------------------------------------------------
module status_text_render #(
   parameter int PIX_WIDTH   = 12,
   parameter int START_X     = 670,
   parameter int START_Y     = 430,
   parameter int LINE_CNT    = 4,
   parameter int LINE_LEN    = 16,
   parameter int FONT_X      = 16,
   parameter int FONT_Y      = 32,
   parameter int SCALE_LOG2  = 0,
   parameter int NUM_CNT     = 3,
   parameter int NUM_DIGITS  = 6,
   parameter int NUM_POS     = 6,
   parameter int ROM_LATENCY = 1,
   parameter int BLINK_TICKS = 30_000_000
) (
   input  logic                              clk_i,
   input  logic                              rst_n_i,
   input  logic [PIX_WIDTH-1:0]              pix_x_i,
   input  logic [PIX_WIDTH-1:0]              pix_y_i,
   input  logic                              frame_start_i,
   input  logic                              wr_en_i,
   input  logic [$clog2(LINE_CNT)-1:0]       wr_line_i,
   input  logic [$clog2(LINE_LEN)-1:0]       wr_pos_i,
   input  logic [6:0]                        wr_char_i,
   input  logic [NUM_CNT*NUM_DIGITS*4-1:0]   num_bcd_i,
   input  logic [LINE_CNT-1:0]               blink_mask_i,
   output logic [7+$clog2(FONT_Y)-1:0]       rom_addr_o,
   input  logic [FONT_X-1:0]                 rom_data_i,
   output logic                              draw_o,
   output logic                              in_region_o
);

   localparam int LW      = $clog2(LINE_CNT);
   localparam int CLW     = $clog2(LINE_LEN);
   localparam int RW      = $clog2(FONT_Y);
   localparam int GW      = $clog2(FONT_X);
   localparam int CW_LOG2 = GW + SCALE_LOG2;
   localparam int CH_LOG2 = RW + SCALE_LOG2;
   localparam int BCD_W   = NUM_CNT * NUM_DIGITS * 4;
   localparam int BW      = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   // Region bounds evaluated in 32 bits so the right/bottom edge never wraps
   // inside PIX_WIDTH.
   localparam logic [31:0] X_LO = 32'(START_X);
   localparam logic [31:0] X_HI = 32'(START_X + (LINE_LEN << CW_LOG2));
   localparam logic [31:0] Y_LO = 32'(START_Y);
   localparam logic [31:0] Y_HI = 32'(START_Y + (LINE_CNT << CH_LOG2));

   localparam logic [6:0] ASCII_SPACE = 7'h20;
   localparam logic [6:0] ASCII_QMARK = 7'h3F;

   // BCD digit to ASCII; non-decimal digits show as '?'.
   function automatic logic [6:0] digit_ascii(input logic [3:0] dig,
                                              input logic       blank);
      if (blank)
         return ASCII_SPACE;
      else if (dig > 4'd9)
         return ASCII_QMARK;
      else
         return {3'b011, dig};
   endfunction

   // -------------------------------------------------------------------------
   // Character buffer, number snapshot, blink timer
   // -------------------------------------------------------------------------
   logic [6:0]        cbuf [LINE_CNT*LINE_LEN];
   logic [BCD_W-1:0]  snap;
   logic [BW-1:0]     blink_cnt;
   logic              blink_phase;

   // Index widths match LINE_CNT/LINE_LEN exactly (both powers of 2), so an
   // out-of-range write index cannot be expressed and needs no filtering.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < LINE_CNT*LINE_LEN; i++)
            cbuf[i] <= ASCII_SPACE;
      end else if (wr_en_i) begin
         cbuf[{wr_line_i, wr_pos_i}] <= wr_char_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         snap <= '0;
      else if (frame_start_i)
         snap <= num_bcd_i;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_TICKS-1)) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Stage 0: geometry, character select, visibility (combinational)
   // -------------------------------------------------------------------------
   logic [PIX_WIDTH-1:0] dx_p0;
   logic [PIX_WIDTH-1:0] dy_p0;
   logic [31:0]          px32_p0;
   logic [31:0]          py32_p0;
   logic                 vld_p0;
   logic [CLW-1:0]       col_p0;
   logic [LW-1:0]        line_p0;
   logic [RW-1:0]        grow_p0;
   logic [GW-1:0]        gcol_p0;
   logic                 vis_p0;
   logic [6:0]           char_p0;

   assign px32_p0 = 32'(pix_x_i);
   assign py32_p0 = 32'(pix_y_i);
   assign vld_p0  = (px32_p0 >= X_LO) && (px32_p0 < X_HI) &&
                    (py32_p0 >= Y_LO) && (py32_p0 < Y_HI);

   // Outside the region these wrap to arbitrary cells; harmless because the
   // draw flag is qualified by vld.
   assign dx_p0   = pix_x_i - PIX_WIDTH'(START_X);
   assign dy_p0   = pix_y_i - PIX_WIDTH'(START_Y);
   assign col_p0  = CLW'(dx_p0 >> CW_LOG2);
   assign line_p0 = LW'(dy_p0 >> CH_LOG2);
   assign grow_p0 = RW'(dy_p0 >> SCALE_LOG2);
   assign gcol_p0 = GW'(dx_p0 >> SCALE_LOG2);
   assign vis_p0  = !blink_mask_i[line_p0] || blink_phase;

   // Number fields override the buffer. Digits are scanned from most to least
   // significant so 'lead' is true while every digit seen so far is zero.
   always_comb begin
      logic       lead;
      logic [3:0] dig;
      logic       blank;
      char_p0 = cbuf[{line_p0, col_p0}];
      lead    = 1'b1;
      dig     = 4'd0;
      blank   = 1'b0;
      for (int k = 0; k < NUM_CNT; k++) begin
         lead = 1'b1;
         for (int d = NUM_DIGITS-1; d >= 0; d--) begin
            dig  = snap[(k*NUM_DIGITS + d)*4 +: 4];
            lead = lead && (dig == 4'd0);
`ifdef STATUS_TEXT_ZERO_BLANK_EN
            blank = lead && (d != 0);
`else
            blank = 1'b0;
`endif
            if ((line_p0 == LW'(k)) && (col_p0 == CLW'(NUM_POS + NUM_DIGITS - 1 - d)))
               char_p0 = digit_ascii(dig, blank);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stage 1: ROM address and sideband; sideband then delayed by ROM_LATENCY.
   // Element i of each *_p1 array is i cycles behind stage 1, so element
   // ROM_LATENCY lines up with rom_data_i.
   // -------------------------------------------------------------------------
   logic           vld_p1  [ROM_LATENCY+1];
   logic           vis_p1  [ROM_LATENCY+1];
   logic [GW-1:0]  gcol_p1 [ROM_LATENCY+1];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rom_addr_o <= '0;
         for (int i = 0; i <= ROM_LATENCY; i++) begin
            vld_p1[i]  <= 1'b0;
            vis_p1[i]  <= 1'b0;
            gcol_p1[i] <= '0;
         end
      end else begin
         rom_addr_o <= {char_p0, grow_p0};
         vld_p1[0]  <= vld_p0;
         vis_p1[0]  <= vis_p0;
         gcol_p1[0] <= gcol_p0;
         for (int i = 1; i <= ROM_LATENCY; i++) begin
            vld_p1[i]  <= vld_p1[i-1];
            vis_p1[i]  <= vis_p1[i-1];
            gcol_p1[i] <= gcol_p1[i-1];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stage 2: pixel select from the ROM row
   // -------------------------------------------------------------------------
   logic [GW-1:0] bit_sel_p2;
   assign bit_sel_p2 = GW'(FONT_X-1) - gcol_p1[ROM_LATENCY];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         draw_o      <= 1'b0;
         in_region_o <= 1'b0;
      end else begin
         draw_o      <= vld_p1[ROM_LATENCY] && vis_p1[ROM_LATENCY] &&
                        rom_data_i[bit_sel_p2];
         in_region_o <= vld_p1[ROM_LATENCY];
      end
   end

endmodule

// File: tb/tb_status_text_render.sv
module tb_status_text_render;

   localparam int BT = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] pix_x = '0;
   logic [11:0] pix_y = '0;
   logic        frame_start = 1'b0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_line = '0;
   logic [3:0]  wr_pos = '0;
   logic [6:0]  wr_char = '0;
   logic [71:0] num_bcd = '0;
   logic [3:0]  blink_mask = '0;

   logic [11:0] rom_addr_a, rom_addr_b;
   logic [15:0] rom_data_a = '0;
   logic [15:0] rom_data_b = '0;
   logic        draw_a, draw_b, inreg_a, inreg_b;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   status_text_render #(.BLINK_TICKS(BT)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .pix_x_i(pix_x), .pix_y_i(pix_y),
      .frame_start_i(frame_start), .wr_en_i(wr_en), .wr_line_i(wr_line),
      .wr_pos_i(wr_pos), .wr_char_i(wr_char), .num_bcd_i(num_bcd),
      .blink_mask_i(blink_mask), .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a),
      .draw_o(draw_a), .in_region_o(inreg_a));

   status_text_render #(.BLINK_TICKS(BT), .SCALE_LOG2(1)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .pix_x_i(pix_x), .pix_y_i(pix_y),
      .frame_start_i(frame_start), .wr_en_i(wr_en), .wr_line_i(wr_line),
      .wr_pos_i(wr_pos), .wr_char_i(wr_char), .num_bcd_i(num_bcd),
      .blink_mask_i(blink_mask), .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b),
      .draw_o(draw_b), .in_region_o(inreg_b));

   // Font ROM model, latency 1: space is blank, 'S' has only glyph column 2
   // lit, every other glyph is fully lit.
   function automatic logic [15:0] rom_fn(input logic [11:0] a);
      logic [6:0] c;
      c = a[11:5];
      if (c == 7'h20)      return 16'h0000;
      else if (c == 7'h53) return 16'h2000;
      else                 return 16'hFFFF;
   endfunction

   always @(posedge clk) begin
      rom_data_a <= rom_fn(rom_addr_a);
      rom_data_b <= rom_fn(rom_addr_b);
   end

   function automatic logic [11:0] mk(input logic [6:0] c, input int r);
      return {c, 5'(r)};
   endfunction

`ifdef STATUS_TEXT_ZERO_BLANK_EN
   localparam logic [6:0] LEAD = 7'h20;
`else
   localparam logic [6:0] LEAD = 7'h30;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else
         n_pass++;
   endtask

   typedef struct {
      string       name;
      bit          scl;
      logic [11:0] x;
      logic [11:0] y;
      bit          chk_addr;
      logic [11:0] addr;
      logic        draw;
      logic        inreg;
   } vec_t;

   function automatic vec_t mv(input string n, input bit s, input int x, input int y,
                               input bit ca, input logic [11:0] a,
                               input logic d, input logic ir);
      vec_t v;
      v.name = n; v.scl = s; v.x = 12'(x); v.y = 12'(y);
      v.chk_addr = ca; v.addr = a; v.draw = d; v.inreg = ir;
      return v;
   endfunction

   // Pixel held from just after an edge; address checked one edge later,
   // draw/in_region three edges later.
   task automatic run_vec(input vec_t v);
      pix_x = v.x;
      pix_y = v.y;
      @(posedge clk); #1;
      if (v.chk_addr)
         chk({v.name, "_addr"}, 32'(v.scl ? rom_addr_b : rom_addr_a), 32'(v.addr));
      @(posedge clk); @(posedge clk); #1;
      chk({v.name, "_draw"}, 32'(v.scl ? draw_b : draw_a), 32'(v.draw));
      chk({v.name, "_inreg"}, 32'(v.scl ? inreg_b : inreg_a), 32'(v.inreg));
   endtask

   task automatic wr(input int l, input int p, input logic [6:0] c);
      wr_line = 2'(l); wr_pos = 4'(p); wr_char = c; wr_en = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   vec_t v0 [7];
   vec_t v1 [5];
   vec_t v2 [8];
   vec_t v3 [6];
   vec_t v4 [5];

   initial begin
      logic [6:0] ch;
      logic       ph;
      logic       ph_hist [64];

      // Phase 1: fresh reset, buffer all spaces
      v0[0] = mv("origin",   0, 670, 430, 1, mk(7'h20, 0),  0, 1);
      v0[1] = mv("left_out", 0, 669, 430, 0, '0,            0, 0);
      v0[2] = mv("top_out",  0, 670, 429, 0, '0,            0, 0);
      v0[3] = mv("corner",   0, 925, 557, 1, mk(7'h20, 31), 0, 1);
      v0[4] = mv("right_out",0, 926, 430, 0, '0,            0, 0);
      v0[5] = mv("bot_out",  0, 670, 558, 0, '0,            0, 0);
      v0[6] = mv("pre_snap", 0, 846, 430, 1, mk(7'h30, 0),  1, 1);
      // Phase 2: after writing 'S' at (0,0) and 'A' at (0,1)
      v1[0] = mv("s_hit",    0, 672, 431, 1, mk(7'h53, 1),  1, 1);
      v1[1] = mv("s_miss",   0, 670, 431, 1, mk(7'h53, 1),  0, 1);
      v1[2] = mv("a_hit",    0, 686, 430, 1, mk(7'h41, 0),  1, 1);
      v1[3] = mv("x_wrap",   0, 942, 430, 0, '0,            0, 0);
      v1[4] = mv("y_wrap",   0, 686, 558, 0, '0,            0, 0);
      // Phase 3: snapshot {123456, 00000A, 000042}
      for (int c = 0; c < 4; c++)
         v2[c] = mv($sformatf("f0_col%0d", 6+c), 0, 766 + 16*c, 430, 1,
                    mk(LEAD, 0), (LEAD != 7'h20), 1);
      v2[4] = mv("f0_col10", 0, 830, 430, 1, mk(7'h34, 0), 1, 1);
      v2[5] = mv("f0_col11", 0, 846, 430, 1, mk(7'h32, 0), 1, 1);
      v2[6] = mv("f1_qmark", 0, 846, 462, 1, mk(7'h3F, 0), 1, 1);
      v2[7] = mv("f2_col6",  0, 766, 494, 1, mk(7'h31, 0), 1, 1);
      // Phase 3b: after simultaneous write 'Q' (3,0) and snapshot field0=7
      v3[0] = mv("hold_col11", 0, 846, 430, 1, mk(7'h32, 0), 1, 1);
      v3[1] = mv("hidden_wr",  0, 846, 430, 1, mk(7'h32, 0), 1, 1);
      v3[2] = mv("snap7",      0, 846, 430, 1, mk(7'h37, 0), 1, 1);
      v3[3] = mv("snap7_c10",  0, 830, 430, 1, mk(LEAD, 0), (LEAD != 7'h20), 1);
      v3[4] = mv("same_cyc_q", 0, 670, 526, 1, mk(7'h51, 0), 1, 1);
      v3[5] = mv("f2_kept",    0, 766, 494, 1, mk(7'h31, 0), 1, 1);
      // Phase 4: 2x scaled instance
      v4[0] = mv("sc_hit",    1, 703,  432, 1, mk(7'h41, 1),  1, 1);
      v4[1] = mv("sc_x_out",  1, 1182, 432, 0, '0,            0, 0);
      v4[2] = mv("sc_x_last", 1, 1181, 432, 1, mk(7'h20, 1),  0, 1);
      v4[3] = mv("sc_y_out",  1, 670,  686, 0, '0,            0, 0);
      v4[4] = mv("sc_y_last", 1, 670,  685, 1, mk(7'h51, 31), 1, 1);

      // Reset state
      pix_x = 12'd670; pix_y = 12'd430;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_addr",  32'(rom_addr_a), 32'h0);
      chk("rst_draw",  32'(draw_a), 32'h0);
      chk("rst_inreg", 32'(inreg_a), 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(v0[i]);

      wr(0, 0, 7'h53);
      wr(0, 1, 7'h41);
      for (int i = 0; i < 5; i++) run_vec(v1[i]);

      num_bcd = {24'h123456, 24'h00000A, 24'h000042};
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      for (int i = 0; i < 8; i++) run_vec(v2[i]);

      // BCD change with no frame_start must not show
      num_bcd[23:0] = 24'h000099;
      run_vec(v3[0]);
      // Write under a field is stored but hidden
      wr(0, 11, 7'h5A);
      run_vec(v3[1]);
      // Write and snapshot in the same cycle
      num_bcd[23:0] = 24'h000007;
      frame_start = 1'b1;
      wr(3, 0, 7'h51);
      frame_start = 1'b0;
      for (int i = 2; i < 6; i++) run_vec(v3[i]);

      for (int i = 0; i < 5; i++) run_vec(v4[i]);

      // Blink: reset mid-frame, line 2 col 11 shows '0' from the cleared
      // snapshot (fully lit glyph). Phase after n edges is 1 for n/8 even.
      blink_mask = 4'b0100;
      pix_x = 12'd846; pix_y = 12'd494;
      rst_n = 1'b0;
      #1;
      chk("rst2_addr",  32'(rom_addr_a), 32'h0);
      chk("rst2_draw",  32'(draw_a), 32'h0);
      chk("rst2_inreg", 32'(inreg_a), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ph_hist[0] = 1'b1;
      for (int m = 1; m < 44; m++) begin
         @(posedge clk); #1;
         ph_hist[m] = ((m / BT) % 2) == 0;
         ph = (m < 3) ? 1'b0 : ph_hist[m-3];
         chk($sformatf("blink_l2_c%0d", m), 32'(draw_a), 32'(ph));
         chk($sformatf("blink_ir_c%0d", m), 32'(inreg_a), 32'(m >= 3));
      end
      ch = 7'h30;
      pix_y = 12'd430;
      repeat (3) @(posedge clk);
      for (int m = 0; m < 20; m++) begin
         @(posedge clk); #1;
         chk($sformatf("blink_l0_c%0d", m), 32'(draw_a), 32'(rom_fn({ch, 5'd0}) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
